// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined control decoder: opcode enums, control bundle and FSM states.
package ctrl_pkg;

  localparam int unsigned ROP_W_DEF = 4;
  localparam int unsigned IOP_W_DEF = 3;

  typedef enum logic [ROP_W_DEF-1:0] {
    ADD, SUB, AND, OR, XOR, NOR, SLT, SGT,
    LW, SW, MUL, DIV, BR, J, SET, LA
  } rop_e;

  typedef enum logic [IOP_W_DEF-1:0] {
    ADDI, SUBI, ANDI, SLL, SRL, SETI
  } iop_e;

  typedef struct packed {
    logic reg_write;
    logic reg_set;
    logic mem_write;
    logic mem_to_reg;
    logic ctrl_branch;
    logic alu_src;
    logic illegal;
  } ctrl_t;

  typedef enum logic [0:0] {
    RUN,
    LD_BUBBLE
  } dec_state_e;

endpackage

// File: rtl/ctrl_decoder_pipe_if.sv
// Fetch-side handshake and registered control bundle of the decoder.
interface ctrl_decoder_pipe_if #(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned ROP_W   = 4,
  parameter int unsigned IOP_W   = 3,
  parameter int unsigned CNT_W   = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               out_valid;
  logic               out_ready;
  logic               type_code;
  logic [ROP_W-1:0]   r_op;
  logic [IOP_W-1:0]   i_op;
  logic               reg_write;
  logic               reg_set;
  logic               mem_write;
  logic               mem_to_reg;
  logic               ctrl_branch;
  logic               alu_src;
  logic               illegal;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, type_code, r_op, i_op, reg_write, reg_set, mem_write,
           mem_to_reg, ctrl_branch, alu_src, illegal, stall_cnt
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, type_code, r_op, i_op, reg_write, reg_set, mem_write,
           mem_to_reg, ctrl_branch, alu_src, illegal, stall_cnt
  );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure combinational decode of one instruction word into the control bundle.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned ROP_W   = 4,
  parameter int unsigned IOP_W   = 3
) (
  input  logic [INSTR_W-1:0] i_instr,
  output ctrl_t              o_ctrl
);

  logic [ROP_W-1:0] w_rop;
  logic [IOP_W-1:0] w_iop;
  logic             w_unused_bits;

  assign w_rop = i_instr[ROP_W-1:0];
  assign w_iop = i_instr[IOP_W-1:0];
  // Bits between the opcode field and the type code carry operands, not control.
  assign w_unused_bits = ^i_instr[INSTR_W-2:ROP_W];

  always_comb begin
    o_ctrl = '0;
    if (i_instr[INSTR_W-1]) begin
      if (w_iop <= IOP_W'(SETI)) begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end else begin
        o_ctrl.illegal = 1'b1;
      end
    end else begin
      case (w_rop)
        ROP_W'(LW): begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
        end
        ROP_W'(SW):             o_ctrl.mem_write   = 1'b1;
        ROP_W'(BR), ROP_W'(J):  o_ctrl.ctrl_branch = 1'b1;
        ROP_W'(SET):            o_ctrl.reg_set     = 1'b1;
        default:                o_ctrl.reg_write   = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_decoder_pipe.sv
// Registered control decoder with valid/ready handshake, LW load-use bubble and flush.
module ctrl_decoder_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W        = 9,
  parameter int unsigned ROP_W          = 4,
  parameter int unsigned IOP_W          = 3,
  parameter bit          LOAD_USE_STALL = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  ctrl_decoder_pipe_if.slave bus
);

  dec_state_e       r_state;
  dec_state_e       w_state_d;
  logic             r_out_valid;
  logic             r_type;
  logic [ROP_W-1:0] r_rop;
  logic [IOP_W-1:0] r_iop;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;

  ctrl_t w_ctrl;
  logic  w_in_ready;
  logic  w_accept;
  logic  w_consume;
  logic  w_cnt_sat;

  ctrl_decode_comb #(
    .INSTR_W (INSTR_W),
    .ROP_W   (ROP_W),
    .IOP_W   (IOP_W)
  ) u_decode (
    .i_instr (bus.instr),
    .o_ctrl  (w_ctrl)
  );

  assign w_in_ready = !reset && !flush && (r_state == RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_consume  = r_out_valid && bus.out_ready;
  assign w_cnt_sat  = &r_stall_cnt;

  // mem_to_reg is set only for LW, so it doubles as the load detector.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      RUN:       if (w_accept && w_ctrl.mem_to_reg && LOAD_USE_STALL) w_state_d = LD_BUBBLE;
      LD_BUBBLE: if (w_consume) w_state_d = RUN;
      default:   w_state_d = RUN;
    endcase
    if (flush) w_state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_out_valid <= 1'b0;
      r_type      <= 1'b0;
      r_rop       <= '0;
      r_iop       <= '0;
      r_ctrl      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == LD_BUBBLE) && !w_cnt_sat) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_type      <= bus.instr[INSTR_W-1];
        r_rop       <= bus.instr[ROP_W-1:0];
        r_iop       <= bus.instr[IOP_W-1:0];
        r_ctrl      <= w_ctrl;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.type_code   = r_type;
  assign bus.r_op        = r_rop;
  assign bus.i_op        = r_iop;
  assign bus.reg_write   = r_ctrl.reg_write;
  assign bus.reg_set     = r_ctrl.reg_set;
  assign bus.mem_write   = r_ctrl.mem_write;
  assign bus.mem_to_reg  = r_ctrl.mem_to_reg;
  assign bus.ctrl_branch = r_ctrl.ctrl_branch;
  assign bus.alu_src     = r_ctrl.alu_src;
  assign bus.illegal     = r_ctrl.illegal;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: doc/ctrl_decoder_pipe.md
# ctrl_decoder_pipe

Registered, parametrised successor to the processor's combinational control decoder. It accepts one fetched instruction per cycle over a valid/ready handshake and produces a registered control bundle one cycle later. It flags illegal encodings and inserts a one-cycle load-use bubble after LW. It sits between the fetch stage and the regfile/ALU/data-memory datapath and honours a synchronous flush from the branch unit.

## Interface
- `INSTR_W`, 9: instruction width; bit `INSTR_W-1` is the type code (1 = I-type).
- `ROP_W`, 4: R-type opcode field, `instr[ROP_W-1:0]`.
- `IOP_W`, 3: I-type opcode field, `instr[IOP_W-1:0]`.
- `LOAD_USE_STALL`, 1: 1 enables the LW bubble; 0 disables it (state stays RUN).
- `CNT_W`, 16: width of the stall counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard the output stage and bubble state.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: decoder accepts `instr` this cycle.
- `instr` in `INSTR_W`: instruction.
- `out_valid` out 1: control bundle valid.
- `out_ready` in 1: downstream consumes the bundle.
- `type_code` out 1: registered `instr[INSTR_W-1]`.
- `r_op` out `ROP_W`: registered R opcode field.
- `i_op` out `IOP_W`: registered I opcode field.
- `reg_write`, `reg_set`, `mem_write`, `mem_to_reg`, `ctrl_branch`, `alu_src` out 1 each: registered control enables.
- `illegal` out 1: registered flag for an undefined encoding.
- `stall_cnt` out `CNT_W`: saturating count of bubble cycles.

## Operation
- Decode table, I-type (`type_code`=1):
  - iOp 000–101 (ADDI, SUBI, ANDI, SLL, SRL, SETI): `reg_write`=1, `alu_src`=1.
  - iOp 110 and 111: `illegal`=1, all enables 0.
- Decode table, R-type:
  - rOp 0000–0111, 1010, 1011, 1111: `reg_write`=1.
  - 1000 (LW): `reg_write`=1, `mem_to_reg`=1.
  - 1001 (SW): `mem_write`=1.
  - 1100 (BR), 1101 (J): `ctrl_branch`=1.
  - 1110 (SET): `reg_set`=1.
- Any enable not listed for an opcode is 0.
- Acceptance: `in_ready = !reset && !flush && state==RUN && (!out_valid || out_ready)`. The instruction is accepted when `in_valid && in_ready`.
- On acceptance, the output register loads the decoded bundle and `out_valid`=1.
- If the output is consumed and nothing is accepted, `out_valid`=0. The remaining outputs hold their last values.
- State machine:
  - RUN → LD_BUBBLE when an LW is accepted and `LOAD_USE_STALL`=1.
  - LD_BUBBLE → RUN on the cycle the LW bundle is consumed (`out_valid && out_ready`).
  - In LD_BUBBLE, `in_ready`=0.
  - `stall_cnt` increments once per LD_BUBBLE cycle and saturates at all-ones.
- Flush: on the next edge `out_valid`=0 and state=RUN. No instruction is accepted in the flush cycle. `stall_cnt` is kept.
- Reset: on the next edge all outputs are 0, `stall_cnt`=0 and state=RUN. Reset has priority over flush and acceptance.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears with `out_valid` after edge N.
- Throughput is 1 per cycle while `out_ready`=1, except after LW.
- LW accepted at edge N with `out_ready` held at 1:
  - LW is consumed in cycle N+1.
  - `in_ready`=0 in cycle N+1.
  - The next instruction is accepted at edge N+2.
  - `out_valid`=0 in cycle N+2 (the bubble).
  - `stall_cnt` += 1.
- Backpressure: while `out_valid && !out_ready`, the bundle is held stable and `in_ready`=0.
- A simultaneous consume and accept in the same cycle is legal, with no bubble unless the consumed bundle is LW.
- A flush while in LD_BUBBLE with the LW still unconsumed drops the LW. `in_ready` returns to 1 the cycle after the flush.

## Structure
- Package `ctrl_pkg` holds:
  - the opcode enums `rop_e` (ADD…LA) and `iop_e` (ADDI…SETI);
  - the packed struct `ctrl_t` carrying the seven control bits;
  - the state enum `dec_state_e` {RUN, LD_BUBBLE}.
- Sub-module `ctrl_decode_comb` is a pure function of `instr` to `ctrl_t`. The top level holds the handshake, state register, output register and counter.

## Test plan
- Reset, then `instr`=9'b1_00000_000 (ADDI) with `in_valid`=1 → one cycle later `out_valid`=1, `reg_write`=1, `alu_src`=1, all other enables 0, `illegal`=0.
- Sweep all 16 rOp and 8 iOp values back-to-back with `out_ready`=1 → one bundle per cycle matching the decode table. iOp 110 and 111 give `illegal`=1 and all enables 0.
- LW (9'b0_0000_1000) followed by ADD (9'b0_0000_0000), `out_ready`=1 → `in_ready`=0 for exactly one cycle, `out_valid` pattern 1,0,1, `stall_cnt`=1. Repeat with `LOAD_USE_STALL`=0 → pattern 1,1 and `stall_cnt`=0.
- Hold `out_ready`=0 for 3 cycles with SW at the output → `mem_write`=1 stays stable and `in_ready`=0 throughout. Raising `out_ready` releases it and the next instruction is accepted in the same cycle.
- Assert `flush` while LW sits unconsumed in LD_BUBBLE → next cycle `out_valid`=0, `in_ready`=1; the following BR decodes with `ctrl_branch`=1.
- Assert `reset` mid-stream with `stall_cnt`=5 → next cycle all outputs are 0, `stall_cnt`=0 and `in_ready`=1 once `reset` is released.
